// File: rtl/prog_loader_pkg.sv
// Shared state encoding, CRC constants and width helpers for the tinyFPGA bitstream loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        WAIT,
        LOAD,
        DONE
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // One bit of MSB-first CRC-16/CCITT.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/prog_clk_div.sv
// progClk generator: level toggles every CLK_HALF clk cycles while run is high;
// rise/fall flag the clk edge on which the level is about to change.
module prog_clk_div
    import prog_loader_pkg::*;
#(
    parameter int CLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW   = cnt_width(CLK_HALF);
    localparam logic [CW-1:0] LAST = CW'(CLK_HALF - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = run && !clr && (cnt == LAST);
    assign rise = wrap && !level;
    assign fall = wrap && level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (run) begin
            if (wrap) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_bitstream_loader.sv
// Byte-stream to tinyFPGA programming-pin serializer; shifts exactly CHAIN_LEN bits LSB first.
// Optional PROG_READBACK_EN adds rb_crc, a CRC-16/CCITT of the old chain contents seen on progDataOut.
module prog_bitstream_loader
    import prog_loader_pkg::*;
#(
    parameter  int CHAIN_LEN  = 1024,
    parameter  int CLK_HALF   = 2,
    parameter  int RST_CYCLES = 4,
    localparam int BW         = cnt_width(CHAIN_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          progClk,
    output logic          progRst,
    output logic          progEn,
    output logic          progDataIn,
    input  logic          progDataOut,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] bit_cnt
`ifdef PROG_READBACK_EN
    ,
    output logic [15:0]   rb_crc
`endif
);

    localparam int            RW       = cnt_width(RST_CYCLES);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [7:0]    sr;
    logic [2:0]    idx;
    logic          div_run;
    logic          div_clr;
    logic          clk_rise;
    logic          clk_fall;
    logic          restart;

    // s_ready is the only output decoded straight from state.
    assign s_ready = (state == WAIT);
    assign div_run = (state == LOAD);
    assign div_clr = abort || (state != LOAD);
    assign restart = start && !abort && (state == IDLE || state == DONE);

    prog_clk_div #(
        .CLK_HALF(CLK_HALF)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .run  (div_run),
        .clr  (div_clr),
        .level(progClk),
        .rise (clk_rise),
        .fall (clk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            idx        <= '0;
            bit_cnt    <= '0;
            progRst    <= 1'b0;
            progEn     <= 1'b0;
            progDataIn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            // bit_cnt deliberately holds so the host can see how far the load got
            state      <= IDLE;
            progRst    <= 1'b0;
            progEn     <= 1'b0;
            progDataIn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RESET;
                        rst_cnt <= '0;
                        bit_cnt <= '0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        progRst <= 1'b1;
                    end
                end
                RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= WAIT;
                        progRst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (s_valid) begin
                        state      <= LOAD;
                        idx        <= '0;
                        progEn     <= 1'b1;
                        progDataIn <= s_data[0];
                    end
                end
                LOAD: begin
                    // Data advances on the falling progClk edge so it is stable at the next rise.
                    if (clk_fall) begin
                        bit_cnt    <= bit_cnt + 1'b1;
                        idx        <= idx + 1'b1;
                        progDataIn <= sr[1];
                        if (bit_cnt == BIT_LAST) begin
                            state      <= DONE;
                            progEn     <= 1'b0;
                            progDataIn <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if (idx == 3'd7) begin
                            state <= WAIT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!abort && s_ready && s_valid) begin
            sr <= s_data;
        end else if (!abort && div_run && clk_fall) begin
            sr <= {1'b0, sr[7:1]};
        end
    end

`ifdef PROG_READBACK_EN
    // The chain tail is sampled just before progClk rises, i.e. before the chain shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_crc <= '0;
        end else if (restart) begin
            rb_crc <= CRC_INIT;
        end else if (!abort && div_run && clk_rise) begin
            rb_crc <= crc_step(rb_crc, progDataOut);
        end
    end
`else
    logic unused_readback;
    logic unused_rise;
    logic unused_restart;
    assign unused_readback = progDataOut;
    assign unused_rise     = clk_rise;
    assign unused_restart  = restart;
`endif

endmodule

// File: tb/tb_prog_bitstream_loader.sv
// Bench for prog_bitstream_loader: two configurations driven with fixed and random byte streams,
// checked against the expected LSB-first bit sequence truncated to the chain length.
module tb_prog_bitstream_loader;

    localparam int A_LEN  = 16;
    localparam int A_HALF = 1;
    localparam int A_RST  = 4;
    localparam int B_LEN  = 10;
    localparam int B_HALF = 2;
    localparam int B_RST  = 3;
    localparam int A_BW   = $clog2(A_LEN + 1);
    localparam int B_BW   = $clog2(B_LEN + 1);

    int compared   = 0;
    int mismatched = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_start = 1'b0, a_abort = 1'b0, a_s_valid = 1'b0;
    logic [7:0]      a_s_data = '0;
    logic            a_s_ready, a_progClk, a_progRst, a_progEn, a_progDataIn, a_progDataOut;
    logic            a_busy, a_done;
    logic [A_BW-1:0] a_bit_cnt;

    logic            b_start = 1'b0, b_abort = 1'b0, b_s_valid = 1'b0;
    logic [7:0]      b_s_data = '0;
    logic            b_s_ready, b_progClk, b_progRst, b_progEn, b_progDataIn;
    logic            b_progDataOut = 1'b0;
    logic            b_busy, b_done;
    logic [B_BW-1:0] b_bit_cnt;

`ifdef PROG_READBACK_EN
    logic [15:0] a_rb_crc;
    logic [15:0] b_rb_crc_unused;
`endif

    prog_bitstream_loader #(.CHAIN_LEN(A_LEN), .CLK_HALF(A_HALF), .RST_CYCLES(A_RST)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .s_data(a_s_data),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .progClk(a_progClk), .progRst(a_progRst),
        .progEn(a_progEn), .progDataIn(a_progDataIn), .progDataOut(a_progDataOut),
        .busy(a_busy), .done(a_done), .bit_cnt(a_bit_cnt)
`ifdef PROG_READBACK_EN
        , .rb_crc(a_rb_crc)
`endif
    );

    prog_bitstream_loader #(.CHAIN_LEN(B_LEN), .CLK_HALF(B_HALF), .RST_CYCLES(B_RST)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .s_data(b_s_data),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .progClk(b_progClk), .progRst(b_progRst),
        .progEn(b_progEn), .progDataIn(b_progDataIn), .progDataOut(b_progDataOut),
        .busy(b_busy), .done(b_done), .bit_cnt(b_bit_cnt)
`ifdef PROG_READBACK_EN
        , .rb_crc(b_rb_crc_unused)
`endif
    );

    // Chain model: bits captured at each progClk rise; old contents of A's chain leave from the tail.
    logic        rx_a[$];
    logic        rx_b[$];
    logic [7:0]  tx_a[$];
    logic [7:0]  tx_b[$];
    logic [15:0] pre_a = 16'h1234;
    int nrise_a = 0, en_bad_a = 0, en_bad_b = 0;
    int rstcyc_a = 0, rstcyc_b = 0, hicyc_a = 0, hicyc_b = 0, acc_a = 0, acc_b = 0;

    assign a_progDataOut = (nrise_a < 16) ? pre_a[nrise_a[3:0]] : 1'b0;

    always @(posedge a_progClk or posedge a_start) begin
        if (a_start) begin
            rx_a.delete();
            nrise_a  <= 0;
            en_bad_a <= 0;
        end else begin
            rx_a.push_back(a_progDataIn);
            nrise_a <= nrise_a + 1;
            if (!a_progEn) en_bad_a <= en_bad_a + 1;
        end
    end

    always @(posedge b_progClk or posedge b_start) begin
        if (b_start) begin
            rx_b.delete();
            en_bad_b <= 0;
        end else begin
            rx_b.push_back(b_progDataIn);
            if (!b_progEn) en_bad_b <= en_bad_b + 1;
        end
    end

    always @(posedge clk) begin
        if (a_start) begin
            rstcyc_a <= 0;
            hicyc_a  <= 0;
        end else begin
            if (a_progRst) rstcyc_a <= rstcyc_a + 1;
            if (a_progClk) hicyc_a <= hicyc_a + 1;
        end
        if (b_start) begin
            rstcyc_b <= 0;
            hicyc_b  <= 0;
        end else begin
            if (b_progRst) rstcyc_b <= rstcyc_b + 1;
            if (b_progClk) hicyc_b <= hicyc_b + 1;
        end
        if (a_s_valid && a_s_ready) acc_a <= acc_a + 1;
        if (b_s_valid && b_s_ready) acc_b <= acc_b + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_bit(input logic [7:0] q[$], input int i);
        logic [7:0] byt;
        byt = q[i / 8];
        return byt[i % 8];
    endfunction

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic start_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b, output bit ok);
        int c0;
        c0 = acc_a;
        ok = 1'b0;
        a_s_data = b;
        a_s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (acc_a != c0) begin
                ok = 1'b1;
                break;
            end
        end
        a_s_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, output bit ok);
        int c0;
        c0 = acc_b;
        ok = 1'b0;
        b_s_data = b;
        b_s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (acc_b != c0) begin
                ok = 1'b1;
                break;
            end
        end
        b_s_valid = 1'b0;
    endtask

    task automatic wait_a(input bit want_done, input int cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (want_done ? (a_done === 1'b1) : (int'(a_bit_cnt) == cnt)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_a(output bit ok);
        bit s;
        ok = 1'b1;
        start_a();
        foreach (tx_a[i]) begin
            send_a(tx_a[i], s);
            if (!s) ok = 1'b0;
        end
        wait_a(1'b1, 0, s);
        if (!s) ok = 1'b0;
    endtask

    task automatic load_b(output bit ok);
        bit s;
        ok = 1'b1;
        start_b();
        foreach (tx_b[i]) begin
            send_b(tx_b[i], s);
            if (!s) ok = 1'b0;
        end
        for (int i = 0; i < 500 && b_done !== 1'b1; i++) @(negedge clk);
        if (b_done !== 1'b1) ok = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        compared++;
        if ({a_s_ready, a_progClk, a_progRst, a_progEn, a_progDataIn, a_busy, a_done, a_bit_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_held_a: outputs %b, required all 0",
                     {a_s_ready, a_progClk, a_progRst, a_progEn, a_progDataIn, a_busy, a_done, a_bit_cnt});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({a_s_ready, a_progClk, a_progRst, a_progEn, a_progDataIn, a_busy, a_done, a_bit_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_idle_a: outputs %b, required all 0",
                     {a_s_ready, a_progClk, a_progRst, a_progEn, a_progDataIn, a_busy, a_done, a_bit_cnt});
        end
        compared++;
        if ({b_s_ready, b_progClk, b_progRst, b_progEn, b_progDataIn, b_busy, b_done, b_bit_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_idle_b: outputs %b, required all 0",
                     {b_s_ready, b_progClk, b_progRst, b_progEn, b_progDataIn, b_busy, b_done, b_bit_cnt});
        end
    endtask

    task automatic test_basic();
        bit ok;
        int errs, acc0;
        tx_a.delete();
        tx_a.push_back(8'hA5);
        tx_a.push_back(8'h3C);
        acc0 = acc_a;
        load_a(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL basic_complete: load stalled, required done"); end
        compared++;
        if (rstcyc_a != A_RST) begin
            mismatched++; $display("FAIL basic_rst_cycles: got %0d, required %0d", rstcyc_a, A_RST);
        end
        errs = 0;
        for (int i = 0; i < A_LEN; i++) if (i >= rx_a.size() || rx_a[i] !== exp_bit(tx_a, i)) errs++;
        compared++;
        if (rx_a.size() != A_LEN || errs != 0) begin
            mismatched++;
            $display("FAIL basic_bits: got %0d rises with %0d wrong bits, required %0d rises, 0 wrong",
                     rx_a.size(), errs, A_LEN);
        end
        compared++;
        if (hicyc_a != A_LEN * A_HALF) begin
            mismatched++; $display("FAIL basic_clk_high: got %0d cycles, required %0d", hicyc_a, A_LEN * A_HALF);
        end
        compared++;
        if ({a_done, a_busy, a_progEn, a_progClk, a_s_ready} !== 5'b10000 || int'(a_bit_cnt) != A_LEN) begin
            mismatched++;
            $display("FAIL basic_done_state: done/busy/en/clk/rdy=%b bit_cnt=%0d, required 10000 and %0d",
                     {a_done, a_busy, a_progEn, a_progClk, a_s_ready}, a_bit_cnt, A_LEN);
        end
        compared++;
        if (en_bad_a != 0 || acc_a - acc0 != 2) begin
            mismatched++;
            $display("FAIL basic_handshake: en_low_rises=%0d bytes=%0d, required 0 and 2", en_bad_a, acc_a - acc0);
        end
    endtask

    task automatic test_random_a();
        bit ok;
        int errs;
        for (int it = 0; it < 3; it++) begin
            tx_a.delete();
            tx_a.push_back(8'($urandom_range(0, 255)));
            tx_a.push_back(8'($urandom_range(0, 255)));
            load_a(ok);
            errs = 0;
            for (int i = 0; i < A_LEN; i++) if (i >= rx_a.size() || rx_a[i] !== exp_bit(tx_a, i)) errs++;
            compared++;
            if (!ok || rx_a.size() != A_LEN || errs != 0 || int'(a_bit_cnt) != A_LEN) begin
                mismatched++;
                $display("FAIL random_a_%0d: bytes %h %h ok=%0d rises=%0d wrong=%0d bit_cnt=%0d, required %0d rises 0 wrong",
                         it, tx_a[0], tx_a[1], ok, rx_a.size(), errs, a_bit_cnt, A_LEN);
            end
        end
    endtask

    task automatic test_truncate_b();
        bit ok;
        int errs, acc0, rdy_seen;
        tx_b.delete();
        tx_b.push_back(8'hFF);
        tx_b.push_back(8'h01);
        acc0 = acc_b;
        load_b(ok);
        compared++;
        if (!ok || rstcyc_b != B_RST) begin
            mismatched++; $display("FAIL trunc_start: ok=%0d rst_cycles=%0d, required 1 and %0d", ok, rstcyc_b, B_RST);
        end
        errs = 0;
        for (int i = 0; i < B_LEN; i++) if (i >= rx_b.size() || rx_b[i] !== exp_bit(tx_b, i)) errs++;
        compared++;
        if (rx_b.size() != B_LEN || errs != 0 || en_bad_b != 0) begin
            mismatched++;
            $display("FAIL trunc_bits: rises=%0d wrong=%0d en_low=%0d, required %0d, 0, 0", rx_b.size(), errs, en_bad_b, B_LEN);
        end
        compared++;
        if (rx_b.size() != B_LEN || rx_b[8] !== 1'b1 || rx_b[9] !== 1'b0) begin
            mismatched++; $display("FAIL trunc_tail: last two bits not 1,0 (rises=%0d)", rx_b.size());
        end
        compared++;
        if (hicyc_b != B_LEN * B_HALF || int'(b_bit_cnt) != B_LEN || b_done !== 1'b1) begin
            mismatched++;
            $display("FAIL trunc_done: clk_high=%0d bit_cnt=%0d done=%b, required %0d, %0d, 1",
                     hicyc_b, b_bit_cnt, b_done, B_LEN * B_HALF, B_LEN);
        end
        rdy_seen = 0;
        b_s_data = 8'h77;
        b_s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_s_ready !== 1'b0) rdy_seen++;
        end
        b_s_valid = 1'b0;
        compared++;
        if (rdy_seen != 0 || acc_b - acc0 != 2) begin
            mismatched++;
            $display("FAIL trunc_third_byte: ready_cycles=%0d bytes=%0d, required 0 and 2", rdy_seen, acc_b - acc0);
        end
        tx_b.delete();
        tx_b.push_back(8'($urandom_range(0, 255)));
        tx_b.push_back(8'($urandom_range(0, 255)));
        load_b(ok);
        errs = 0;
        for (int i = 0; i < B_LEN; i++) if (i >= rx_b.size() || rx_b[i] !== exp_bit(tx_b, i)) errs++;
        compared++;
        if (!ok || rx_b.size() != B_LEN || errs != 0) begin
            mismatched++;
            $display("FAIL random_b: bytes %h %h ok=%0d rises=%0d wrong=%0d, required %0d rises 0 wrong",
                     tx_b[0], tx_b[1], ok, rx_b.size(), errs, B_LEN);
        end
    endtask

    task automatic test_stall();
        bit ok, s;
        int bad, errs;
        tx_a.delete();
        tx_a.push_back(8'($urandom_range(0, 255)));
        tx_a.push_back(8'($urandom_range(0, 255)));
        start_a();
        send_a(tx_a[0], ok);
        wait_a(1'b0, 8, s);
        ok = ok && s;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_progClk !== 1'b0 || a_progEn !== 1'b1 || int'(a_bit_cnt) != 8 || a_s_ready !== 1'b1) bad++;
        end
        compared++;
        if (!ok || bad != 0) begin
            mismatched++; $display("FAIL stall_hold: reached=%0d bad_cycles=%0d, required 1 and 0", ok, bad);
        end
        send_a(tx_a[1], s);
        wait_a(1'b1, 0, ok);
        errs = 0;
        for (int i = 0; i < A_LEN; i++) if (i >= rx_a.size() || rx_a[i] !== exp_bit(tx_a, i)) errs++;
        compared++;
        if (!s || !ok || rx_a.size() != A_LEN || errs != 0) begin
            mismatched++;
            $display("FAIL stall_resume: rises=%0d wrong=%0d, required %0d rises 0 wrong", rx_a.size(), errs, A_LEN);
        end
    endtask

    task automatic test_abort();
        bit ok, s;
        int errs;
        start_a();
        send_a(8'($urandom_range(0, 255)), ok);
        wait_a(1'b0, 5, s);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        compared++;
        if (!ok || !s || {a_busy, a_progEn, a_progClk, a_progRst, a_done, a_s_ready} !== 6'b0 || int'(a_bit_cnt) != 5) begin
            mismatched++;
            $display("FAIL abort_state: busy/en/clk/rst/done/rdy=%b bit_cnt=%0d, required 000000 and 5",
                     {a_busy, a_progEn, a_progClk, a_progRst, a_done, a_s_ready}, a_bit_cnt);
        end
        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        compared++;
        if (a_busy !== 1'b0 || a_progRst !== 1'b0) begin
            mismatched++; $display("FAIL abort_wins: busy=%b progRst=%b, required 0 0", a_busy, a_progRst);
        end
        tx_a.delete();
        tx_a.push_back(8'($urandom_range(0, 255)));
        tx_a.push_back(8'($urandom_range(0, 255)));
        load_a(ok);
        errs = 0;
        for (int i = 0; i < A_LEN; i++) if (i >= rx_a.size() || rx_a[i] !== exp_bit(tx_a, i)) errs++;
        compared++;
        if (!ok || rx_a.size() != A_LEN || errs != 0 || rstcyc_a != A_RST) begin
            mismatched++;
            $display("FAIL abort_reload: ok=%0d rises=%0d wrong=%0d rst_cycles=%0d, required 1, %0d, 0, %0d",
                     ok, rx_a.size(), errs, rstcyc_a, A_LEN, A_RST);
        end
    endtask

    task automatic test_async_rst();
        bit ok, s;
        start_a();
        send_a(8'($urandom_range(0, 255)), ok);
        wait_a(1'b0, 3, s);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (!ok || !s ||
            {a_s_ready, a_progClk, a_progRst, a_progEn, a_progDataIn, a_busy, a_done, a_bit_cnt} !== '0) begin
            mismatched++;
            $display("FAIL async_rst: outputs %b before next edge, required all 0",
                     {a_s_ready, a_progClk, a_progRst, a_progEn, a_progDataIn, a_busy, a_done, a_bit_cnt});
        end
        #1 rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({a_busy, a_progEn, a_progClk, a_bit_cnt} !== '0) begin
            mismatched++; $display("FAIL async_rst_idle: busy/en/clk/cnt=%b, required all 0", {a_busy, a_progEn, a_progClk, a_bit_cnt});
        end
    endtask

`ifdef PROG_READBACK_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] bits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 16; i++) c = (c[15] ^ bits[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    task automatic test_readback();
        bit ok;
        tx_a.delete();
        tx_a.push_back(8'h00);
        tx_a.push_back(8'h00);
        load_a(ok);
        compared++;
        if (!ok || a_rb_crc !== crc_ref(pre_a)) begin
            mismatched++; $display("FAIL readback_crc: got %h, required %h", a_rb_crc, crc_ref(pre_a));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random_a();
        test_truncate_b();
        test_stall();
        test_abort();
`ifdef PROG_READBACK_EN
        test_readback();
`endif
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
